// File: rtl/eva_mem_arb_if.sv
// eva_mem_arb_if: requester command/response signals and the single-port
// memory-wrapper signals shared by the EVA memory arbiter.
interface eva_mem_arb_if #(
    parameter int NREQ     = 4,
    parameter int AW       = 16,
    parameter int WIDTH    = 32,
    parameter int MASKBITS = 1
);
    // Requester command side, requester i occupies slice i of each flat bus
    logic [NREQ-1:0]          req_vld;
    logic [NREQ-1:0]          req_wr;
    logic [NREQ-1:0]          req_lock;
    logic [NREQ*AW-1:0]       req_addr;
    logic [NREQ*MASKBITS-1:0] req_wmsk;
    logic [NREQ*WIDTH-1:0]    req_wdata;
    logic [NREQ-1:0]          req_rdy;

    // Read response side
    logic [NREQ-1:0]          rsp_vld;
    logic [WIDTH-1:0]         rsp_data;

    // Memory wrapper side
    logic                     mem_rd;
    logic [MASKBITS-1:0]      mem_we;
    logic [AW-1:0]            mem_addr;
    logic [WIDTH-1:0]         mem_wdata;
    logic [WIDTH-1:0]         mem_rdata;

    // The arbiter itself
    modport slave (
        input  req_vld, req_wr, req_lock, req_addr, req_wmsk, req_wdata, mem_rdata,
        output req_rdy, rsp_vld, rsp_data, mem_rd, mem_we, mem_addr, mem_wdata
    );

    // The requester agents together with the memory wrapper
    modport master (
        output req_vld, req_wr, req_lock, req_addr, req_wmsk, req_wdata, mem_rdata,
        input  req_rdy, rsp_vld, rsp_data, mem_rd, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/eva_mem_arb.sv
// eva_mem_arb: round-robin arbiter/sequencer sharing one single-port EVA memory
// wrapper between NREQ requesters. One registered memory command per cycle,
// reads answered to their owner two cycles after accept, optional bounded lock.
module eva_mem_arb #(
    parameter int NREQ     = 4,
    parameter int AW       = 16,
    parameter int WIDTH    = 32,
    parameter int MASKBITS = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic         clk,
    input  logic         rst,
    eva_mem_arb_if.slave bus
);
    localparam int              IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              LW  = $clog2(MAX_LOCK) + 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t               state;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        rr_ptr;
    logic [LW-1:0]        lock_cnt;

    logic                 grant_vld;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        next_ptr;

    logic                 sel_wr;
    logic                 sel_lock;
    logic [AW-1:0]        sel_addr;
    logic [MASKBITS-1:0]  sel_wmsk;
    logic [WIDTH-1:0]     sel_wdata;

    logic                 tag_vld;
    logic                 tag_rd;
    logic [IW-1:0]        tag_owner;

    // Pick this cycle's grantee: the lock owner, or the first valid requester at/after rr_ptr
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path holds a stale value (no latch).
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!rst) begin
            if (state == ST_LOCKED) begin
                grant_vld = bus.req_vld[owner];
                grant_idx = owner;
            end else begin
                // Scan farthest to nearest so the nearest valid requester is the last write and wins.
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (bus.req_vld[IW'((int'(rr_ptr) + k) % NREQ)]) begin
                        grant_vld = 1'b1;
                        grant_idx = IW'((int'(rr_ptr) + k) % NREQ);
                    end
                end
            end
        end
    end

    assign bus.req_rdy = grant_vld ? (ONE << grant_idx) : '0;
    assign next_ptr    = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);

    // Fields of the granted command
    assign sel_wr    = bus.req_wr[grant_idx];
    assign sel_lock  = bus.req_lock[grant_idx];
    assign sel_addr  = bus.req_addr[int'(grant_idx)*AW +: AW];
    assign sel_wmsk  = bus.req_wmsk[int'(grant_idx)*MASKBITS +: MASKBITS];
    assign sel_wdata = bus.req_wdata[int'(grant_idx)*WIDTH +: WIDTH];

    // Arbitration FSM: round-robin pointer and the bounded lock on one owner
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
        end else begin
            if (grant_vld) begin
                rr_ptr <= next_ptr;
            end
            case (state)
                ST_IDLE: begin
                    // With MAX_LOCK=1 a single grant already exhausts the burst, so lock is ignored.
                    if (grant_vld && sel_lock && (MAX_LOCK > 1)) begin
                        state    <= ST_LOCKED;
                        owner    <= grant_idx;
                        lock_cnt <= LW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!grant_vld) begin
                        // Owner went idle: drop the lock, others compete again next cycle.
                        state    <= ST_IDLE;
                        lock_cnt <= '0;
                    end else if (sel_lock && (lock_cnt < LW'(MAX_LOCK - 1))) begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end else begin
                        // Lock released, or this grant was the MAX_LOCK-th of the burst.
                        state    <= ST_IDLE;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Command register: the accepted command is driven to the memory wrapper the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_rd    <= 1'b0;
            bus.mem_we    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (grant_vld) begin
            bus.mem_rd   <= !sel_wr;
            bus.mem_we   <= sel_wr ? sel_wmsk : '0;
            bus.mem_addr <= sel_addr;
            if (sel_wr) begin
                bus.mem_wdata <= sel_wdata;
            end
        end else begin
            // Idle cycle: no strobe, address and write data hold.
            bus.mem_rd <= 1'b0;
            bus.mem_we <= '0;
        end
    end

    // Response stage: tag travels with the command, then read data is captured for its owner
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld      <= 1'b0;
            tag_rd       <= 1'b0;
            tag_owner    <= '0;
            bus.rsp_vld  <= '0;
            bus.rsp_data <= '0;
        end else begin
            tag_vld   <= grant_vld;
            tag_rd    <= grant_vld && !sel_wr;
            tag_owner <= grant_idx;
            // The wrapper answers combinationally while the read command is on the bus.
            if (tag_vld && tag_rd) begin
                bus.rsp_vld  <= ONE << tag_owner;
                bus.rsp_data <= bus.mem_rdata;
            end else begin
                bus.rsp_vld  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_eva_mem_arb.sv
// tb_eva_mem_arb: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_eva_mem_arb;
    localparam int NREQ     = 4;
    localparam int AW       = 16;
    localparam int WIDTH    = 32;
    localparam int MASKBITS = 1;
    localparam int MAX_LOCK = 8;
    localparam int MEMW     = 1024;

    logic clk;
    logic rst;

    eva_mem_arb_if #(.NREQ(NREQ), .AW(AW), .WIDTH(WIDTH), .MASKBITS(MASKBITS)) bus ();

    eva_mem_arb #(
        .NREQ(NREQ), .AW(AW), .WIDTH(WIDTH), .MASKBITS(MASKBITS), .MAX_LOCK(MAX_LOCK)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory wrapper: combinational read, write at the clock edge, cleared by reset
    logic [WIDTH-1:0] mem_arr [0:MEMW-1];
    assign bus.mem_rdata = mem_arr[bus.mem_addr[9:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEMW; i++) mem_arr[i] <= '0;
        end else if (bus.mem_we[0]) begin
            mem_arr[bus.mem_addr[9:0]] <= bus.mem_wdata;
        end
    end

    // Stimulus registers, applied at the falling edge by cycle()
    logic             t_rst;
    logic             t_vld   [NREQ];
    logic             t_wr    [NREQ];
    logic             t_lock  [NREQ];
    logic [AW-1:0]    t_addr  [NREQ];
    logic [WIDTH-1:0] t_wdata [NREQ];
    logic             t_wmsk  [NREQ];

    // Reference model: commands take effect in accept order on a plain memory array
    typedef struct {
        int               t;
        int               owner;
        logic [WIDTH-1:0] data;
    } rsp_t;

    logic [WIDTH-1:0] ref_mem [0:MEMW-1];
    rsp_t             rsp_q [$];
    int               rr;
    int               lk_owner;
    int               burst;
    logic             e_rd;
    logic             e_we;
    logic [AW-1:0]    e_addr;
    logic [WIDTH-1:0] e_wdata;
    logic             just_rst;

    // Observation logs indexed by cycle number
    logic [NREQ-1:0]  obs_rdy      [$];
    logic [NREQ-1:0]  obs_rsp_vld  [$];
    logic [WIDTH-1:0] obs_rsp_data [$];
    logic             obs_mem_rd   [$];

    int cyc;
    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Index of the single set bit, -1 for none, -2 for more than one
    function automatic int decode(input logic [NREQ-1:0] v);
        int idx;
        int n;
        idx = -1;
        n   = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                idx = i;
                n++;
            end
        end
        return (n > 1) ? -2 : idx;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // Who the model grants given the current stimulus
    function automatic int model_grant();
        int i;
        if (t_rst) return -1;
        if (lk_owner >= 0) return t_vld[lk_owner] ? lk_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (rr + k) % NREQ;
            if (t_vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < NREQ; i++) begin
            t_vld[i]   = 1'b0;
            t_wr[i]    = 1'b0;
            t_lock[i]  = 1'b0;
            t_addr[i]  = AW'(i);
            t_wdata[i] = '0;
            t_wmsk[i]  = 1'b1;
        end
    endtask

    task automatic drive();
        rst = t_rst;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_vld[i]                        = t_vld[i];
            bus.req_wr[i]                         = t_wr[i];
            bus.req_lock[i]                       = t_lock[i];
            bus.req_addr[i*AW +: AW]              = t_addr[i];
            bus.req_wmsk[i*MASKBITS +: MASKBITS]  = MASKBITS'(t_wmsk[i]);
            bus.req_wdata[i*WIDTH +: WIDTH]       = t_wdata[i];
        end
    endtask

    // One clock cycle: apply stimulus, compare against the model, advance the model
    task automatic cycle();
        int              g;
        logic [NREQ-1:0] exp_rv;
        logic [WIDTH-1:0] a_data;
        @(negedge clk);
        drive();
        #1;
        g = model_grant();
        check($sformatf("req_rdy@%0d", cyc), 64'(bus.req_rdy), 64'(onehot(g)));
        check($sformatf("mem_rd@%0d", cyc), 64'(bus.mem_rd), 64'(e_rd));
        check($sformatf("mem_we@%0d", cyc), 64'(bus.mem_we), 64'(e_we));
        if (e_rd || e_we) check($sformatf("mem_addr@%0d", cyc), 64'(bus.mem_addr), 64'(e_addr));
        if (e_we) check($sformatf("mem_wdata@%0d", cyc), 64'(bus.mem_wdata), 64'(e_wdata));
        exp_rv = '0;
        if (rsp_q.size() > 0 && rsp_q[0].t == cyc) begin
            exp_rv = onehot(rsp_q[0].owner);
            check($sformatf("rsp_data@%0d", cyc), 64'(bus.rsp_data), 64'(rsp_q[0].data));
            void'(rsp_q.pop_front());
        end
        check($sformatf("rsp_vld@%0d", cyc), 64'(bus.rsp_vld), 64'(exp_rv));
        if (just_rst) begin
            check($sformatf("rst_addr@%0d", cyc), 64'(bus.mem_addr), 64'(0));
            check($sformatf("rst_wdata@%0d", cyc), 64'(bus.mem_wdata), 64'(0));
            check($sformatf("rst_rdata@%0d", cyc), 64'(bus.rsp_data), 64'(0));
        end
        obs_rdy.push_back(bus.req_rdy);
        obs_rsp_vld.push_back(bus.rsp_vld);
        obs_rsp_data.push_back(bus.rsp_data);
        obs_mem_rd.push_back(bus.mem_rd);

        // Model update for the coming clock edge
        if (t_rst) begin
            e_rd    = 1'b0;
            e_we    = 1'b0;
            e_addr  = '0;
            e_wdata = '0;
            rsp_q.delete();
            rr       = 0;
            lk_owner = -1;
            burst    = 0;
            just_rst = 1'b1;
            for (int i = 0; i < MEMW; i++) ref_mem[i] = '0;
        end else begin
            just_rst = 1'b0;
            if (g >= 0) begin
                rr = (g + 1) % NREQ;
                if (lk_owner >= 0) begin
                    burst++;
                    if (!t_lock[g] || burst >= MAX_LOCK) begin
                        lk_owner = -1;
                        burst    = 0;
                    end
                end else if (t_lock[g] && MAX_LOCK > 1) begin
                    lk_owner = g;
                    burst    = 1;
                end
                e_addr = t_addr[g];
                if (t_wr[g]) begin
                    e_rd = 1'b0;
                    e_we = t_wmsk[g];
                    if (t_wmsk[g]) begin
                        e_wdata = t_wdata[g];
                        ref_mem[t_addr[g][9:0]] = t_wdata[g];
                    end
                end else begin
                    e_rd   = 1'b1;
                    e_we   = 1'b0;
                    a_data = ref_mem[t_addr[g][9:0]];
                    rsp_q.push_back('{t: cyc + 2, owner: g, data: a_data});
                end
            end else begin
                e_rd = 1'b0;
                e_we = 1'b0;
                lk_owner = -1;
                burst    = 0;
            end
        end
        cyc++;
    endtask

    initial begin
        int c0, c1, c2, c3, c4, c5;
        int lock_pct;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rr       = 0;
        lk_owner = -1;
        burst    = 0;
        e_rd     = 1'b0;
        e_we     = 1'b0;
        e_addr   = '0;
        e_wdata  = '0;
        just_rst = 1'b1;
        for (int i = 0; i < MEMW; i++) ref_mem[i] = '0;
        t_rst = 1'b1;
        clear_inputs();
        drive();

        // Reset state
        repeat (3) cycle();
        t_rst = 1'b0;

        // Single write then read of 0x10 by requester 0
        clear_inputs();
        t_vld[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 16'h0010; t_wdata[0] = 32'hA5A5_0001;
        cycle();
        clear_inputs();
        t_vld[0] = 1'b1; t_wr[0] = 1'b0; t_addr[0] = 16'h0010;
        c0 = cyc;
        cycle();
        clear_inputs();
        repeat (3) cycle();
        check("single_accept", 64'(obs_rdy[c0]), 64'(4'b0001));
        check("single_rsp_t1", 64'(obs_rsp_vld[c0+1]), 64'(4'b0000));
        check("single_rsp_t2", 64'(obs_rsp_vld[c0+2]), 64'(4'b0001));
        check("single_data", 64'(obs_rsp_data[c0+2]), 64'(32'hA5A5_0001));

        // Write by requester 0 followed next cycle by a read of the same word by requester 1
        t_vld[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 16'h0020; t_wdata[0] = 32'h1234_5678;
        cycle();
        clear_inputs();
        t_vld[1] = 1'b1; t_wr[1] = 1'b0; t_addr[1] = 16'h0020;
        c1 = cyc;
        cycle();
        clear_inputs();
        repeat (3) cycle();
        check("raw_accept", 64'(obs_rdy[c1]), 64'(4'b0010));
        check("raw_rsp", 64'(obs_rsp_vld[c1+2]), 64'(4'b0010));
        check("raw_data", 64'(obs_rsp_data[c1+2]), 64'(32'h1234_5678));

        // Fairness: everyone reading continuously from a fresh reset
        t_rst = 1'b1;
        repeat (2) cycle();
        t_rst = 1'b0;
        for (int i = 0; i < NREQ; i++) t_vld[i] = 1'b1;
        c2 = cyc;
        repeat (12) cycle();
        clear_inputs();
        repeat (3) cycle();
        for (int k = 0; k < 12; k++) begin
            check($sformatf("fair_gnt%0d", k), 64'(decode(obs_rdy[c2+k])), 64'(k % NREQ));
            check($sformatf("fair_rsp%0d", k), 64'(decode(obs_rsp_vld[c2+k+2])), 64'(k % NREQ));
        end

        // Lock bound: requester 1 holds lock while requester 2 waits
        t_vld[1] = 1'b1; t_lock[1] = 1'b1; t_vld[2] = 1'b1;
        c3 = cyc;
        repeat (10) cycle();
        clear_inputs();
        repeat (2) cycle();
        for (int k = 0; k < MAX_LOCK; k++) begin
            check($sformatf("lock_gnt%0d", k), 64'(decode(obs_rdy[c3+k])), 64'(1));
        end
        check("lock_then_req2", 64'(decode(obs_rdy[c3+MAX_LOCK])), 64'(2));

        // Lock release: requester 3 locks for three commands, releases on the fourth
        t_vld[3] = 1'b1; t_lock[3] = 1'b1;
        c4 = cyc;
        cycle();
        t_vld[0] = 1'b1;
        repeat (2) cycle();
        t_lock[3] = 1'b0;
        cycle();
        for (int i = 0; i < NREQ; i++) t_vld[i] = 1'b1;
        cycle();
        clear_inputs();
        repeat (3) cycle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rel_gnt%0d", k), 64'(decode(obs_rdy[c4+k])), 64'(3));
        end
        check("rel_rr_resume", 64'(decode(obs_rdy[c4+4])), 64'(0));

        // Reset one cycle after a read accept
        t_vld[2] = 1'b1; t_addr[2] = 16'h0010;
        c5 = cyc;
        cycle();
        clear_inputs();
        t_rst = 1'b1;
        cycle();
        t_rst = 1'b0;
        for (int i = 0; i < NREQ; i++) t_vld[i] = 1'b1;
        repeat (2) cycle();
        clear_inputs();
        repeat (3) cycle();
        check("mid_accept", 64'(obs_rdy[c5]), 64'(4'b0100));
        check("mid_mem_rd", 64'(obs_mem_rd[c5+2]), 64'(0));
        check("mid_rsp_t2", 64'(obs_rsp_vld[c5+2]), 64'(0));
        check("mid_rsp_t3", 64'(obs_rsp_vld[c5+3]), 64'(0));
        check("mid_rr_zero", 64'(decode(obs_rdy[c5+2])), 64'(0));

        // Randomized traffic, lighter locking first, heavy locking later
        for (int n = 0; n < 3000; n++) begin
            lock_pct = (n < 1500) ? 25 : 90;
            t_rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NREQ; i++) begin
                t_vld[i]   = ($urandom_range(0, 3) != 0);
                t_wr[i]    = 1'($urandom_range(0, 1));
                t_lock[i]  = ($urandom_range(0, 99) < lock_pct);
                t_addr[i]  = AW'($urandom_range(0, 15));
                t_wdata[i] = WIDTH'($urandom);
                t_wmsk[i]  = ($urandom_range(0, 7) != 0);
            end
            cycle();
        end
        t_rst = 1'b0;
        clear_inputs();
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
